mem_burst_responder: RTL and testbench
======================================

// Module: mem_burst_responder
// PURPOSE
//  Memory-side responder for the cache controller's line-burst traffic: word RAM serving
//  write-back bursts and line-fill read bursts, one word per beat, one beat per cycle.
//  Read data is combinational so the controller captures it in the beat cycle.
//  Burst FSM checks beat ordering, flags protocol errors, reports completions and counts bursts.
//  Sits between cache_controller's mem_addr/mem_write_en outputs and the top-level bus.
// PARAMETERS
//  OFFSET_WIDTH    4   byte-offset bits per line; LINE_SIZE = 2**(OFFSET_WIDTH-2) words; must be >= 3
//  MEM_ADDR_WIDTH  10  word-index bits; RAM depth = 2**MEM_ADDR_WIDTH 32-bit words
//  CNT_WIDTH       16  width of burst statistic counters
// PORTS
//  clk_i          in   1          clock, all state updates on posedge
//  rst_i          in   1          synchronous reset, active-high
//  mem_en_i       in   1          beat strobe: an access is present this cycle
//  mem_write_en_i in   1          1 = write beat, 0 = read beat (valid with mem_en_i)
//  mem_addr_i     in   32         byte address; bits [1:0] ignored
//  mem_wdata_i    in   32         write data (valid with mem_en_i & mem_write_en_i)
//  err_clr_i      in   1          clears sticky err_o
//  mem_rdata_o    out  32         combinational read data for mem_addr_i
//  busy_o         out  1          1 while a burst is open (state != IDLE)
//  burst_done_o   out  1          one-cycle pulse: a full LINE_SIZE burst completed
//  burst_write_o  out  1          direction of completed burst, valid with burst_done_o
//  err_o          out  1          sticky protocol-error flag
//  rd_bursts_o    out  CNT_WIDTH  completed read bursts, wraps modulo 2**CNT_WIDTH
//  wr_bursts_o    out  CNT_WIDTH  completed write bursts, wraps modulo 2**CNT_WIDTH
// BEHAVIOUR
//  - Reset values: busy_o=0, burst_done_o=0, burst_write_o=0, err_o=0, counters=0, state=IDLE.
//    RAM contents are NOT cleared; writes presented during a reset cycle are suppressed.
//  - RAM index = mem_addr_i[MEM_ADDR_WIDTH+1:2]; higher address bits ignored (aliasing).
//  - mem_rdata_o = RAM[index] combinationally, regardless of mem_en_i; same-cycle write to the
//    same index: mem_rdata_o shows OLD data, new data visible the next cycle.
//  - Write: RAM[index] <= mem_wdata_i on posedge when mem_en_i & mem_write_en_i & ~rst_i.
//    Every beat is performed on the RAM, including erroneous beats.
//  - States: IDLE, WR_BURST, RD_BURST. Registers: line base (addr[31:OFFSET_WIDTH]), beat_cnt.
//  - IDLE, beat with word offset 0 -> WR_BURST/RD_BURST per mem_write_en_i, latch base, beat_cnt=1.
//  - IDLE, beat with offset != 0 -> single access, no state change, no error.
//  - In burst, expected beat: same direction, same base, word offset == beat_cnt.
//    Match: beat_cnt++; if beat_cnt was LINE_SIZE-1 -> IDLE, next cycle burst_done_o=1,
//    burst_write_o=direction, matching counter +1 (same edge as done pulse registers).
//    Mismatch: err_o<=1, burst aborted, beat reprocessed as IDLE beat in the same cycle
//    (offset 0 opens a new burst immediately); aborted burst is not counted.
//  - mem_en_i low during a burst: gap, state and beat_cnt held, no error.
//  - err_clr_i clears err_o next edge; simultaneous new error and err_clr_i -> err_o=1.
//  - Latency: read 0 cycles; write 1 edge; done pulse 1 cycle after final beat's edge.
// TESTING
//  - Preload RAM[0x10..0x13]=A0..A3; read beats 0x40,44,48,4C consecutive -> rdata A0..A3
//    same cycles, busy_o=1 for 3 cycles, burst_done_o=1 & burst_write_o=0 next cycle, rd_bursts_o=1.
//  - Write beats 0x80..0x8C data D0..D3 then read 0x80..0x8C -> rdata D0..D3, wr_bursts_o=1, err_o=0.
//  - Write burst with 2-cycle gap after beat 1 -> completes normally, err_o=0, done 1 cycle after beat 3.
//  - Read 0x40,0x44 then read 0x4C -> err_o=1, no done, busy_o=0; then err_clr_i=1 -> err_o=0.
//  - Read 0x40,0x44 then read 0x100 (offset 0) -> err_o=1, new burst open (busy_o=1); finish at
//    0x10C -> done, rd_bursts_o=1.
//  - rst_i asserted mid write burst with beat 0x88 -> state IDLE, RAM[0x22] unchanged, outputs
//    at reset values; counters at 0xFFFF + one burst -> wrap to 0x0000.

Source files
------------

// File: rtl/mem_burst_responder.sv
// Memory-side word RAM for cache line bursts: combinational read, registered write,
// plus a burst tracker that checks beat ordering, flags errors and counts completed bursts.
module mem_burst_responder #(
  parameter int OFFSET_WIDTH   = 4,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_en_i,
  input  logic                 mem_write_en_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [31:0]          mem_wdata_i,
  input  logic                 err_clr_i,
  output logic [31:0]          mem_rdata_o,
  output logic                 busy_o,
  output logic                 burst_done_o,
  output logic                 burst_write_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] rd_bursts_o,
  output logic [CNT_WIDTH-1:0] wr_bursts_o
);

  localparam int BEAT_W = OFFSET_WIDTH - 2;
  localparam int BASE_W = 32 - OFFSET_WIDTH;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t                    state;
  logic [BASE_W-1:0]         base_q;
  logic [BEAT_W-1:0]         beat_cnt;
  logic [31:0]               mem [0:2**MEM_ADDR_WIDTH-1];

  logic [MEM_ADDR_WIDTH-1:0] index;
  logic [BEAT_W-1:0]         offset;
  logic [BASE_W-1:0]         base;
  logic                      beat_ok;
  logic                      unused_addr_bits;

  assign index            = mem_addr_i[MEM_ADDR_WIDTH+1:2];
  assign offset           = mem_addr_i[OFFSET_WIDTH-1:2];
  assign base             = mem_addr_i[31:OFFSET_WIDTH];
  assign unused_addr_bits = ^mem_addr_i[1:0];

  assign mem_rdata_o = mem[index];
  assign busy_o      = (state != IDLE);

  // Every beat lands in the RAM, including beats the tracker flags as errors.
  always_ff @(posedge clk_i) begin
    if (mem_en_i && mem_write_en_i && !rst_i)
      mem[index] <= mem_wdata_i;
  end

  always_comb begin
    beat_ok = 1'b0;
    if (state != IDLE)
      beat_ok = (mem_write_en_i == (state == WR_BURST)) &&
                (base == base_q) && (offset == beat_cnt);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      base_q        <= '0;
      beat_cnt      <= '0;
      burst_done_o  <= 1'b0;
      burst_write_o <= 1'b0;
      err_o         <= 1'b0;
      rd_bursts_o   <= '0;
      wr_bursts_o   <= '0;
    end else begin
      burst_done_o <= 1'b0;
      if (err_clr_i)
        err_o <= 1'b0;
      if (mem_en_i) begin
        if (beat_ok) begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
          if (&beat_cnt) begin
            state         <= IDLE;
            burst_done_o  <= 1'b1;
            burst_write_o <= mem_write_en_i;
            if (mem_write_en_i)
              wr_bursts_o <= wr_bursts_o + CNT_WIDTH'(1);
            else
              rd_bursts_o <= rd_bursts_o + CNT_WIDTH'(1);
          end
        end else begin
          // Out-of-order beat aborts the burst and is then treated as a fresh idle beat.
          if (state != IDLE)
            err_o <= 1'b1;
          if (offset == '0) begin
            state    <= mem_write_en_i ? WR_BURST : RD_BURST;
            base_q   <= base;
            beat_cnt <= BEAT_W'(1);
          end else begin
            state <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder; a second instance with 2-bit counters
// exercises counter wrap-around on the shared stimulus.
module tb_mem_burst_responder;

  logic        clk = 1'b0;
  logic        rst, en, we, clr;
  logic [31:0] addr, wdata;

  logic [31:0] rdata, rdata2;
  logic        busy, done, bw, err;
  logic        busy2, done2, bw2, err2;
  logic [15:0] rdc, wrc;
  logic [1:0]  rdc2, wrc2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_burst_responder dut (
    .clk_i(clk), .rst_i(rst), .mem_en_i(en), .mem_write_en_i(we),
    .mem_addr_i(addr), .mem_wdata_i(wdata), .err_clr_i(clr),
    .mem_rdata_o(rdata), .busy_o(busy), .burst_done_o(done),
    .burst_write_o(bw), .err_o(err), .rd_bursts_o(rdc), .wr_bursts_o(wrc)
  );

  mem_burst_responder #(.CNT_WIDTH(2)) dut_w (
    .clk_i(clk), .rst_i(rst), .mem_en_i(en), .mem_write_en_i(we),
    .mem_addr_i(addr), .mem_wdata_i(wdata), .err_clr_i(clr),
    .mem_rdata_o(rdata2), .busy_o(busy2), .burst_done_o(done2),
    .burst_write_o(bw2), .err_o(err2), .rd_bursts_o(rdc2), .wr_bursts_o(wrc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [31:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
  endtask

  task automatic idle();
    en = 1'b0; we = 1'b0;
  endtask

  // Four consecutive beats; optionally checks read data in each beat cycle and busy after beats 0..2.
  task automatic burst(input logic w, input logic [31:0] base, input logic [31:0] d0,
                       input bit chk_rd, input string tag);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, w, base + 32'(4*i), d0 + 32'(i));
      #1;
      if (chk_rd) chk({tag, "_rdata"}, rdata, d0 + 32'(i));
      tick();
      if (i < 3) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; clr = 1'b0; addr = '0; wdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_bw",   {31'd0, bw},   0);
    chk("rst_err",  {31'd0, err},  0);
    chk("rst_rdc",  {16'd0, rdc},  0);
    chk("rst_wrc",  {16'd0, wrc},  0);

    // write burst then read back
    burst(1'b1, 32'h80, 32'hD000_0000, 1'b0, "wr80");
    chk("wr80_done", {31'd0, done}, 1);
    chk("wr80_bw",   {31'd0, bw},   1);
    chk("wr80_wrc",  {16'd0, wrc},  1);
    chk("wr80_idle", {31'd0, busy}, 0);
    chk("wr80_err",  {31'd0, err},  0);
    tick();
    chk("wr80_pulse", {31'd0, done}, 0);
    burst(1'b0, 32'h80, 32'hD000_0000, 1'b1, "rd80");
    chk("rd80_done", {31'd0, done}, 1);
    chk("rd80_bw",   {31'd0, bw},   0);
    chk("rd80_rdc",  {16'd0, rdc},  1);

    // single write at non-zero offset: old data same cycle, new data next cycle
    drive(1'b1, 1'b1, 32'h84, 32'h0000_1234);
    #1;
    chk("wr84_old", rdata, 32'hD000_0001);
    tick(); idle(); #1;
    chk("wr84_new",  rdata, 32'h0000_1234);
    chk("wr84_busy", {31'd0, busy}, 0);
    chk("wr84_err",  {31'd0, err},  0);

    // preload line 0x40 then read burst
    burst(1'b1, 32'h40, 32'hA000_0000, 1'b0, "wr40");
    chk("wr40_wrc", {16'd0, wrc}, 2);
    burst(1'b0, 32'h40, 32'hA000_0000, 1'b1, "rd40");
    chk("rd40_done", {31'd0, done}, 1);
    chk("rd40_bw",   {31'd0, bw},   0);
    chk("rd40_rdc",  {16'd0, rdc},  2);

    // write burst with a 2-cycle gap after beat 1
    drive(1'b1, 1'b1, 32'hC0, 32'h1); tick();
    drive(1'b1, 1'b1, 32'hC4, 32'h2); tick();
    idle(); tick();
    chk("gap_busy1", {31'd0, busy}, 1);
    tick();
    chk("gap_busy2", {31'd0, busy}, 1);
    chk("gap_err",   {31'd0, err},  0);
    drive(1'b1, 1'b1, 32'hC8, 32'h3); tick();
    chk("gap_nodone", {31'd0, done}, 0);
    drive(1'b1, 1'b1, 32'hCC, 32'h4); tick(); idle();
    chk("gap_done", {31'd0, done}, 1);
    chk("gap_wrc",  {16'd0, wrc},  3);
    chk("gap_err2", {31'd0, err},  0);

    // skipped beat -> error, burst aborted
    drive(1'b1, 1'b0, 32'h40, 0); tick();
    drive(1'b1, 1'b0, 32'h44, 0); tick();
    drive(1'b1, 1'b0, 32'h4C, 0); tick(); idle();
    chk("skip_err",  {31'd0, err},  1);
    chk("skip_busy", {31'd0, busy}, 0);
    chk("skip_done", {31'd0, done}, 0);
    tick();
    chk("skip_sticky", {31'd0, err}, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("skip_clr", {31'd0, err}, 0);
    chk("skip_rdc", {16'd0, rdc}, 2);

    // offset-0 beat mid burst reopens a new burst
    drive(1'b1, 1'b0, 32'h40, 0); tick();
    drive(1'b1, 1'b0, 32'h44, 0); tick();
    drive(1'b1, 1'b0, 32'h100, 0); tick(); idle();
    chk("reopen_err",  {31'd0, err},  1);
    chk("reopen_busy", {31'd0, busy}, 1);
    drive(1'b1, 1'b0, 32'h104, 0); tick();
    drive(1'b1, 1'b0, 32'h108, 0); tick();
    drive(1'b1, 1'b0, 32'h10C, 0); tick(); idle();
    chk("reopen_done", {31'd0, done}, 1);
    chk("reopen_rdc",  {16'd0, rdc},  3);
    chk("wrap_pre",    {30'd0, rdc2}, 3);
    clr = 1'b1; tick(); clr = 1'b0;

    // fourth read burst wraps the 2-bit counter
    burst(1'b0, 32'h40, 32'hA000_0000, 1'b0, "rd40b");
    chk("rd40b_rdc", {16'd0, rdc},  4);
    chk("wrap_rdc2", {30'd0, rdc2}, 0);

    // new error coinciding with clear keeps err set
    drive(1'b1, 1'b0, 32'h40, 0); tick();
    drive(1'b1, 1'b0, 32'h48, 0); clr = 1'b1; tick(); clr = 1'b0; idle();
    chk("errclr_err",  {31'd0, err},  1);
    chk("errclr_busy", {31'd0, busy}, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("errclr_clr", {31'd0, err}, 0);

    // direction change mid burst is an error
    drive(1'b1, 1'b1, 32'h140, 32'h55); tick();
    drive(1'b1, 1'b0, 32'h144, 0); tick(); idle();
    chk("dir_err",  {31'd0, err},  1);
    chk("dir_busy", {31'd0, busy}, 0);

    // reset mid write burst suppresses the write at 0x88
    drive(1'b1, 1'b1, 32'h200, 32'h1); tick();
    drive(1'b1, 1'b1, 32'h204, 32'h2); tick();
    drive(1'b1, 1'b1, 32'h88, 32'h0000_0BAD); rst = 1'b1; tick(); rst = 1'b0; idle();
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_err",  {31'd0, err},  0);
    chk("mrst_done", {31'd0, done}, 0);
    chk("mrst_rdc",  {16'd0, rdc},  0);
    chk("mrst_wrc",  {16'd0, wrc},  0);
    addr = 32'h88; #1;
    chk("mrst_ram", rdata, 32'hD000_0002);

    // high address bits alias; read data independent of strobe
    addr = 32'h1084; #1;
    chk("alias_rdata", rdata, 32'h0000_1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
